// File: rtl/mux3_arbiter.sv
// mux3_arbiter: round-robin arbiter sharing one 3:1 select path into a valid/ready output register.
// Optional BURST_LIMIT_EN caps each grant at MAX_BURST beats before rotating.
module mux3_arbiter #(
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    req,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    output logic [2:0]    ack,
    output logic [1:0]    madd,
    output logic          busy,
    output logic [DW-1:0] y,
    output logic          y_valid,
    input  logic          y_ready
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q, state_d;
    logic [1:0]    madd_q, madd_d, last_q, last_d;
    logic          busy_q, busy_d, y_valid_q, y_valid_d;
    logic [DW-1:0] y_q, y_d, sel;
    logic [1:0]    p0, p1, p2;
    logic          can_load, load, req_g, burst_done;

    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
        $error("MAX_BURST must be in 1..15");
    end

    function automatic logic [1:0] inc3(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    function automatic logic bit_at(input logic [2:0] v, input logic [1:0] i);
        return (i == 2'd2) ? v[2] : (i == 2'd1) ? v[1] : v[0];
    endfunction

    always_comb begin
        p0       = inc3(last_q);
        p1       = inc3(p0);
        p2       = inc3(p1);
        req_g    = bit_at(req, madd_q);
        sel      = (madd_q == 2'd2) ? c : (madd_q == 2'd1) ? b : a;
        can_load = !y_valid_q || y_ready;
        ack      = (!rst && state_q == GRANT && req_g && can_load) ? (3'b001 << madd_q) : 3'b000;
        load     = |ack;
    end

`ifdef BURST_LIMIT_EN
    logic [3:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        beat_cnt_d = (state_q == IDLE) ? 4'd0 : load ? beat_cnt_q + 4'd1 : beat_cnt_q;
        burst_done = load && (beat_cnt_q + 4'd1 == 4'(MAX_BURST));
    end

    always_ff @(posedge clk) begin
        if (rst) beat_cnt_q <= 4'd0;
        else     beat_cnt_q <= beat_cnt_d;
    end
`else
    assign burst_done = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        madd_d  = madd_q;
        last_d  = last_q;
        busy_d  = busy_q;
        if (state_q == IDLE && |req) begin
            madd_d  = bit_at(req, p0) ? p0 : bit_at(req, p1) ? p1 : p2;
            state_d = GRANT;
            busy_d  = 1'b1;
        end else if (state_q == GRANT && (!req_g || burst_done)) begin
            // madd is left alone on release so the select code never glitches
            state_d = IDLE;
            busy_d  = 1'b0;
            last_d  = madd_q;
        end
        y_d       = load ? sel : y_q;
        y_valid_d = load || (y_valid_q && !y_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            madd_q    <= 2'd0;
            last_q    <= 2'd2;
            busy_q    <= 1'b0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            madd_q    <= madd_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign madd    = madd_q;
    assign busy    = busy_q;
    assign y       = y_q;
    assign y_valid = y_valid_q;
endmodule

// File: tb/tb_mux3_arbiter.sv
// tb_mux3_arbiter: directed test of mux3_arbiter grant order, handshakes and reset.
module tb_mux3_arbiter;
    logic       clk = 1'b0;
    logic       rst, y_ready, busy, y_valid;
    logic [2:0] req, ack;
    logic [7:0] a, b, c, y;
    logic [1:0] madd;
    int checks = 0;
    int failures = 0;

    mux3_arbiter #(.DW(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .c(c),
        .ack(ack), .madd(madd), .busy(busy), .y(y), .y_valid(y_valid), .y_ready(y_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic grant_beat(input logic [1:0] g, input logic [7:0] exp_y);
        tick();
        chk("rr_madd", 32'(madd), 32'(g));
        chk("rr_busy", 32'(busy), 32'd1);
        tick();
        chk("rr_y", 32'(y), 32'(exp_y));
        req[g] = 1'b0;
        tick();
        chk("rr_release", 32'(busy), 32'd0);
        req[g] = 1'b1;
    endtask

    initial begin
        rst = 1'b1; req = 3'b111; y_ready = 1'b1;
        a = 8'hA1; b = 8'hB2; c = 8'hC3;
        tick();
        tick();
        chk("rst_madd", 32'(madd), 32'd0);
        chk("rst_y_valid", 32'(y_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        rst = 1'b0;
        tick();
        chk("first_madd", 32'(madd), 32'd0);
        chk("first_busy", 32'(busy), 32'd1);
        chk("first_ack", 32'(ack), 32'b001);
        tick();
        chk("first_y", 32'(y), 32'hA1);
        chk("first_y_valid", 32'(y_valid), 32'd1);
        req = 3'b000;
        tick();
        chk("first_idle_busy", 32'(busy), 32'd0);
        chk("first_idle_madd", 32'(madd), 32'd0);
        chk("first_idle_y_valid", 32'(y_valid), 32'd0);

        // single beat from B; last=A so B is next in order
        req = 3'b010; b = 8'h5A;
        tick();
        chk("single_madd", 32'(madd), 32'd1);
        chk("single_ack", 32'(ack), 32'b010);
        tick();
        chk("single_y", 32'(y), 32'h5A);
        chk("single_y_valid", 32'(y_valid), 32'd1);
        req = 3'b000;
        tick();
        chk("single_busy", 32'(busy), 32'd0);
        chk("single_madd_hold", 32'(madd), 32'd1);

        do_reset();
        req = 3'b111; a = 8'h01; b = 8'h02; c = 8'h03;
        grant_beat(2'd0, 8'h01);
        grant_beat(2'd1, 8'h02);
        grant_beat(2'd2, 8'h03);
        grant_beat(2'd0, 8'h01);
        req = 3'b000;
        tick();
        chk("rr_end_busy", 32'(busy), 32'd0);

        // backpressure on B (last=A)
        req = 3'b010; b = 8'h11;
        tick();
        chk("bp_madd", 32'(madd), 32'd1);
        tick();
        chk("bp_y1", 32'(y), 32'h11);
        b = 8'h22; y_ready = 1'b0;
        settle();
        chk("bp_ack_stall", 32'(ack), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_y_hold", 32'(y), 32'h11);
            chk("bp_valid_hold", 32'(y_valid), 32'd1);
            chk("bp_ack_hold", 32'(ack), 32'd0);
            chk("bp_busy_hold", 32'(busy), 32'd1);
        end
        y_ready = 1'b1;
        settle();
        chk("bp_ack_resume", 32'(ack), 32'b010);
        tick();
        chk("bp_y2", 32'(y), 32'h22);
        chk("bp_y2_valid", 32'(y_valid), 32'd1);
        req = 3'b000;
        tick();
        chk("bp_drain_valid", 32'(y_valid), 32'd0);
        chk("bp_drain_y", 32'(y), 32'h22);
        chk("bp_drain_busy", 32'(busy), 32'd0);

        do_reset();
        req = 3'b101; a = 8'hAA; c = 8'hCC;
        tick();
        chk("burst_grant_a", 32'(madd), 32'd0);
`ifdef BURST_LIMIT_EN
        for (int i = 0; i < 4; i++) begin
            chk("burst_a_ack", 32'(ack), 32'b001);
            tick();
            chk("burst_a_y", 32'(y), 32'hAA);
        end
        chk("burst_a_release", 32'(busy), 32'd0);
        chk("burst_idle_ack", 32'(ack), 32'd0);
        tick();
        chk("burst_grant_c", 32'(madd), 32'd2);
        for (int i = 0; i < 4; i++) begin
            chk("burst_c_ack", 32'(ack), 32'b100);
            tick();
            chk("burst_c_y", 32'(y), 32'hCC);
        end
        chk("burst_c_release", 32'(busy), 32'd0);
        tick();
        chk("burst_regrant_a", 32'(madd), 32'd0);
`else
        for (int i = 0; i < 8; i++) begin
            chk("hold_a_ack", 32'(ack), 32'b001);
            tick();
            chk("hold_a_madd", 32'(madd), 32'd0);
            chk("hold_a_busy", 32'(busy), 32'd1);
            chk("hold_a_y", 32'(y), 32'hAA);
        end
`endif
        req = 3'b000;
        tick();
        tick();

        // reset landing on C's third beat
        do_reset();
        req = 3'b100; c = 8'h3C;
        tick();
        chk("mr_grant_c", 32'(madd), 32'd2);
        tick();
        tick();
        chk("mr_valid_before", 32'(y_valid), 32'd1);
        rst = 1'b1;
        settle();
        chk("mr_ack_in_reset", 32'(ack), 32'd0);
        tick();
        chk("mr_valid", 32'(y_valid), 32'd0);
        chk("mr_madd", 32'(madd), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        rst = 1'b0; req = 3'b101;
        tick();
        chk("mr_a_wins", 32'(madd), 32'd0);
        chk("mr_a_busy", 32'(busy), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mux3_arbiter.md
Name: mux3_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8-bit 3:1 select path between three requesters (A, B, C).
- Drives the 2-bit select code (00=A, 01=B, 10=C) and owns the registered output stage, which uses a valid/ready handshake toward the consumer.
- Each requester uses a req/ack handshake. The arbiter holds a grant for a burst of beats and then rotates.
- Sits between requester datapaths and the shared CPU-internal bus consumer.

Parameters:
- DW, 8: data width of a, b, c and y.
- MAX_BURST, 4: maximum beats per grant; used only when BURST_LIMIT_EN is defined; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- req  in  3  request per requester; bit0=A, bit1=B, bit2=C; held with stable data until acked
- a    in  DW  requester A data
- b    in  DW  requester B data
- c    in  DW  requester C data
- ack  out 3  one-hot beat-accept strobe, combinational; requester advances data on an edge where its ack=1
- madd out 2  registered grant/select code: 00=A, 01=B, 10=C; 11 never driven
- busy out 1  registered; 1 while in GRANT state
- y    out DW  registered output data
- y_valid out 1  registered; y holds a beat not yet taken
- y_ready in  1  consumer accepts y on an edge where y_valid=1 and y_ready=1

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values:
  - state=IDLE, madd=00, busy=0, y=0, y_valid=0.
  - last (last-granted index) = 2, so A has first priority.
  - beat_cnt=0, ack=000.
  - Reset mid-burst: the pending y is discarded and no ack is issued in the reset cycle.
- Output stage:
  - can_load = !y_valid || y_ready.
  - Edge with y_valid && y_ready and no load: y_valid<=0.
  - Edge with load: y <= selected input, y_valid<=1 (load and take in the same edge keeps y_valid=1).
- IDLE state:
  - ack=000.
  - If req!=0: pick the first requesting index in rotating order last+1, last+2, last+3 (mod 3).
  - At that edge: madd<=index, busy<=1, beat_cnt<=0, state<=GRANT.
  - If req==0: stay in IDLE.
- GRANT state, with g=madd:
  - ack[g] = req[g] && can_load; other ack bits are 0.
  - Edge with ack[g]=1: load y from input g, beat_cnt<=beat_cnt+1.
  - Release when req[g]==0. At that edge: state<=IDLE, busy<=0, last<=g. madd keeps its value (no glitch to 00).
- Latency:
  - req rises while IDLE at edge N-1 -> grant at edge N -> earliest beat loaded at edge N+1.
  - Each release costs one IDLE bubble cycle before the next grant.
- Back-to-back beats: sustained 1 beat/clock while req[g]=1 and y_ready=1.
- Backpressure: while y_valid=1 and y_ready=0, ack=000 and y is stable. The grant is held; there is no timeout.
- Simultaneous events:
  - Request arrival during GRANT is ignored until release.
  - A requester dropping req in the same cycle as ack is not legal. Req may fall only after its final ack edge.
- Invariants: ack is one-hot or zero; madd is never 11.

Optional Feature:
- Macro: BURST_LIMIT_EN.
- Defined:
  - On the ack edge where beat_cnt+1 == MAX_BURST, release as well: state<=IDLE, last<=g, even if req[g] stays high.
  - The requester re-arbitrates under round-robin order.
  - beat_cnt is 4 bits.
- Undefined:
  - No beat counter logic.
  - A grant is held for as long as req[g]=1, so one requester can starve the others.

Test Plan:
- Reset: rst=1 for 2 cycles with req=111 -> madd=00, y_valid=0, busy=0, ack=000. After release: A granted first (madd=00 at edge 1, y=a at edge 2).
- Single beat: req=010, b=8'h5A, y_ready=1 -> madd=01 at edge 1; ack=010 in cycle 1; y=8'h5A and y_valid=1 after edge 2. Drop req -> IDLE, busy=0.
- Round-robin: req=111 held, each requester does one beat then drops and re-raises req -> grant order A,B,C,A; madd sequence 00,01,10,00.
- Backpressure: B granted, b=8'h11 then 8'h22, y_ready=0 for 3 cycles -> y stays 8'h11, ack=000. y_ready=1 -> 8'h22 loaded the next edge; no beat lost or duplicated.
- BURST_LIMIT_EN, MAX_BURST=4: A and C hold req continuously, y_ready=1 -> A gets exactly 4 acks, 1 idle cycle, then C gets 4, then A. Without the macro: A is acked indefinitely.
- Mid-burst reset: rst=1 on the third beat of C with y_valid=1 -> next edge y_valid=0, madd=00, busy=0; afterwards A wins over C when both request.
